gf2m_digit_mul: RTL and testbench

GF2M_DIGIT_MUL -- requirements
Module: gf2m_digit_mul

---
 rtl/gf2m_pkg.sv | 18 +
 rtl/gf2m_digit_mul_if.sv | 25 ++
 rtl/gf2m_digit_step.sv | 26 ++
 rtl/gf2m_digit_mul.sv | 105 ++++++++++
 tb/tb_gf2m_digit_mul.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared types and constants for the GF(2^m) digit-serial multiplier.
// Holds the FSM state type, the NIST B-163 reduction terms and the digit count helper.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int B163_M = 163;
  localparam logic [B163_M-1:0] B163_POLY = 163'hC9;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/gf2m_digit_mul_if.sv
// gf2m_digit_mul_if: operand/result valid-ready bundle.
// master drives operands and out_ready, slave returns the product.
interface gf2m_digit_mul_if #(
  parameter int M = 163
);

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] c_out;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, c_out
  );

endinterface

// File: rtl/gf2m_digit_step.sv
// gf2m_digit_step: one digit iteration, nxt = acc*x^D + a*digit mod f.
// Horner over the D digit bits keeps every intermediate reduced to degree < M.
module gf2m_digit_step #(
  parameter int           M    = 163,
  parameter int           D    = 32,
  parameter logic [M-1:0] POLY = M'(163'hC9)
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] nxt
);

  logic [M-1:0] t;

  always_comb begin
    t = acc;
    for (int i = D - 1; i >= 0; i--) begin
      t = {t[M-2:0], 1'b0}
        ^ (t[M-1] ? POLY : '0)
        ^ (digit[i] ? a : '0);
    end
    nxt = t;
  end

endmodule

// File: rtl/gf2m_digit_mul.sv
// gf2m_digit_mul: digit-serial GF(2^M) multiplier, D multiplier bits per cycle.
// Define GF2M_SQR_EN to add the sqr input (square a_in instead of a_in*b_in).
module gf2m_digit_mul
  import gf2m_pkg::*;
#(
  parameter int           M    = 163,
  parameter int           D    = 32,
  parameter logic [M-1:0] POLY = M'(B163_POLY)
) (
  input  logic clk,
  input  logic rstn,
`ifdef GF2M_SQR_EN
  input  logic sqr,
`endif
  gf2m_digit_mul_if.slave bus
);

  localparam int N  = ceil_div(M, D);
  localparam int NW = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  state_t        state_nx;
  logic [M-1:0]  a_q;
  logic [NW-1:0] b_q;
  logic [M-1:0]  acc;
  logic [M-1:0]  acc_step;
  logic [CW-1:0] cnt;
  logic [D-1:0]  digit;
  logic [M-1:0]  b_sel;
  int            idx;

`ifdef GF2M_SQR_EN
  assign b_sel = sqr ? bus.a_in : bus.b_in;
`else
  assign b_sel = bus.b_in;
`endif

  // b_q is zero-padded at the top; counter 0 picks the top digit
  always_comb begin
    idx   = (N - 1 - int'(cnt)) * D;
    digit = b_q[idx +: D];
  end

  gf2m_digit_step #(
    .M    (M),
    .D    (D),
    .POLY (POLY)
  ) u_step (
    .acc   (acc),
    .a     (a_q),
    .digit (digit),
    .nxt   (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a_in;
            b_q <= NW'(b_sel);
            acc <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.c_out     = '0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == CW'(N - 1)) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.c_out     = acc;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// tb_gf2m_digit_mul: directed checks of the digit-serial multiplier.
// Runs D=32 (main), D=1 and D=163 instances; GF2M_SQR_EN adds a squaring vector.
module tb_gf2m_digit_mul;
  import gf2m_pkg::*;

  localparam int           M    = 163;
  localparam int           D    = 32;
  localparam int           N    = ceil_div(M, D);
  localparam logic [M-1:0] POLY = 163'hC9;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [M-1:0] a = '0;
  logic [M-1:0] b = '0;
`ifdef GF2M_SQR_EN
  logic         sqr = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf2m_digit_mul_if #(.M(M)) bus0 ();
  gf2m_digit_mul_if #(.M(M)) bus1 ();
  gf2m_digit_mul_if #(.M(M)) bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.a_in      = a;
  assign bus0.b_in      = b;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.a_in      = a;
  assign bus1.b_in      = b;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.a_in      = a;
  assign bus2.b_in      = b;
  assign bus2.out_ready = out_ready;

  gf2m_digit_mul #(.M(M), .D(D), .POLY(POLY)) dut0 (
    .clk  (clk),
    .rstn (rstn),
`ifdef GF2M_SQR_EN
    .sqr  (sqr),
`endif
    .bus  (bus0.slave)
  );

  gf2m_digit_mul #(.M(M), .D(1), .POLY(POLY)) dut1 (
    .clk  (clk),
    .rstn (rstn),
`ifdef GF2M_SQR_EN
    .sqr  (sqr),
`endif
    .bus  (bus1.slave)
  );

  gf2m_digit_mul #(.M(M), .D(M), .POLY(POLY)) dut2 (
    .clk  (clk),
    .rstn (rstn),
`ifdef GF2M_SQR_EN
    .sqr  (sqr),
`endif
    .bus  (bus2.slave)
  );

  task automatic chk(input string tag, input logic [M-1:0] got,
                     input logic [M-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // schoolbook product then reduction from the top, independent of the digit loop
  function automatic logic [M-1:0] gmul(input logic [M-1:0] x,
                                         input logic [M-1:0] y);
    logic [2*M-2:0] p;
    logic [2*M-2:0] f;
    p = '0;
    for (int i = 0; i < M; i++)
      if (y[i]) p = p ^ ((2*M-1)'(x) << i);
    f = (2*M-1)'({1'b1, POLY});
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (f << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rnd();
    return M'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [M-1:0] av,
                         input logic [M-1:0] bv, input logic [M-1:0] exp,
                         input bit hold);
    int k;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = !hold;
    chk({tag, "_rdy"}, M'(bus0.in_ready), M'(1));
    tick();
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    chk({tag, "_c0busy"}, bus0.c_out, '0);
    k = 0;
    for (int i = 1; i <= N + 5 && k == 0; i++) begin
      tick();
      if (bus0.out_valid) k = i;
    end
    chk({tag, "_lat"}, M'(k + 1), M'(N + 1));
    chk({tag, "_c"}, bus0.c_out, exp);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        chk({tag, "_hold_v"}, M'(bus0.out_valid), M'(1));
        chk({tag, "_hold_c"}, bus0.c_out, exp);
        chk({tag, "_hold_r"}, M'(bus0.in_ready), M'(0));
      end
      out_ready = 1'b1;
    end
    tick();
    chk({tag, "_drop_v"}, M'(bus0.out_valid), M'(0));
    chk({tag, "_idle_r"}, M'(bus0.in_ready), M'(1));
  endtask

  initial begin
    logic [M-1:0] q[$];
    logic [M-1:0] one_hot;
    logic [M-1:0] exp;
    logic [M-1:0] va;
    logic [M-1:0] vb;
    int  last;
    int  n_acc;
    int  n_res;
    int  k1;
    int  k2;
    bit  acc_now;
    bit  anyv;

    tick();
    tick();
    chk("rst_rdy", M'(bus0.in_ready), M'(1));
    chk("rst_val", M'(bus0.out_valid), M'(0));
    chk("rst_c", bus0.c_out, '0);
    rstn = 1'b1;
    tick();

    run_one("one", M'(1), M'(1), M'(1), 1'b0);
    one_hot = '0;
    one_hot[M-1] = 1'b1;
    run_one("wrap", one_hot, M'(2), M'(8'hC9), 1'b0);
    run_one("zero", '0, '1, '0, 1'b1);
    run_one("rnd", 163'h5_1234_5678_9abc_def0_1357_9bdf_0246_8ace_fedc_ba98,
            163'h2_f0f0_0f0f_aaaa_5555_cccc_3333_1111_2222_dead_beef,
            gmul(163'h5_1234_5678_9abc_def0_1357_9bdf_0246_8ace_fedc_ba98,
                 163'h2_f0f0_0f0f_aaaa_5555_cccc_3333_1111_2222_dead_beef),
            1'b0);

    // back-to-back stream with operands changing while busy
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = rnd();
    b         = rnd();
    last      = -1;
    n_acc     = 0;
    n_res     = 0;
    for (int cyc = 0; cyc < 20 * (N + 2) + 20 && n_res < 20; cyc++) begin
      acc_now = bus0.in_ready && in_valid;
      if (acc_now) begin
        q.push_back(gmul(a, b));
        if (last >= 0) chk("b2b_gap", M'(cyc - last), M'(N + 2));
        last = cyc;
        n_acc++;
      end
      if (bus0.out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : ~bus0.c_out;
        chk("b2b_c", bus0.c_out, exp);
        n_res++;
      end
      tick();
      if (acc_now) begin
        if (n_acc == 20) in_valid = 1'b0;
        a = rnd();
        b = rnd();
      end
    end
    in_valid = 1'b0;
    chk("b2b_cnt", M'(n_res), M'(20));
    for (int i = 0; i < 3; i++) tick();

    // reset on the third busy cycle
    a        = rnd();
    b        = rnd();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("abort_rdy", M'(bus0.in_ready), M'(1));
    chk("abort_val", M'(bus0.out_valid), M'(0));
    chk("abort_c", bus0.c_out, '0);
    anyv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      anyv = anyv | bus0.out_valid;
    end
    chk("abort_noval", M'(anyv), M'(0));
    va = rnd();
    vb = rnd();
    run_one("after_rst", va, vb, gmul(va, vb), 1'b0);

`ifdef GF2M_SQR_EN
    one_hot = '0;
    one_hot[100] = 1'b1;
    exp = '0;
    exp[44] = 1'b1;
    exp[43] = 1'b1;
    exp[40] = 1'b1;
    exp[37] = 1'b1;
    sqr = 1'b1;
    run_one("sqr", one_hot, rnd(), exp, 1'b0);
    sqr = 1'b0;
`endif

    // D=1 and D=M instances fed the same pair
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int p = 0; p < 3; p++) begin
      va        = rnd();
      vb        = rnd();
      exp       = gmul(va, vb);
      a         = va;
      b         = vb;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = rnd();
      b        = rnd();
      k1       = 0;
      k2       = 0;
      for (int i = 1; i <= 170; i++) begin
        tick();
        if (bus1.out_valid && k1 == 0) begin
          k1 = i;
          chk("d1_c", bus1.c_out, exp);
        end
        if (bus2.out_valid && k2 == 0) begin
          k2 = i;
          chk("dm_c", bus2.c_out, exp);
        end
      end
      chk("d1_lat", M'(k1 + 1), M'(164));
      chk("dm_lat", M'(k2 + 1), M'(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
